// File: rtl/ss_display_arbiter.sv
// Two-client arbiter for a 4-digit seven-segment display: B has priority, A keeps a minimum hold.
// Optional macro SS_DISPLAY_ARB_BLINK_EN makes the display blink while B owns it.
module ss_display_arbiter #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int BLINK_HALF  = 6_250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic [3:0]  blank_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    input  logic [3:0]  blank_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [6:0]  seg3,
    output logic [6:0]  seg2,
    output logic [6:0]  seg1,
    output logic [6:0]  seg0,
    output logic [3:0]  mask
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 2");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic [27:0]   seg_q, seg_d;
    logic [3:0]    mask_q, mask_d;
    logic          b_dark;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_b)      state_d = OWN_B;
                else if (req_a) state_d = OWN_A;
            end
            OWN_A: begin
                if (!req_a)                             state_d = req_b ? OWN_B : IDLE;
                else if (req_b && hold_cnt_q == HOLD_MAX) state_d = OWN_B;
            end
            OWN_B: begin
                if (!req_b) state_d = req_a ? OWN_A : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts from zero whenever A newly takes ownership.
        hold_cnt_d = '0;
        if (state_q == OWN_A && state_d == OWN_A) begin
            hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
        end
    end

`ifdef SS_DISPLAY_ARB_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_dark_q, blink_dark_d;

    always_comb begin
        blink_cnt_d  = '0;
        blink_dark_d = 1'b0;
        if (state_q == OWN_B && state_d == OWN_B) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d  = '0;
                blink_dark_d = ~blink_dark_q;
            end else begin
                blink_cnt_d  = blink_cnt_q + BW'(1);
                blink_dark_d = blink_dark_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q  <= '0;
            blink_dark_q <= 1'b0;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            blink_dark_q <= blink_dark_d;
        end
    end

    assign b_dark = blink_dark_d;
`else
    assign b_dark = 1'b0;
`endif

    // Outputs follow the next owner so grant and display change on the same edge.
    always_comb begin
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        case (state_d)
            OWN_A:   mask_d = blank_a;
            OWN_B:   mask_d = b_dark ? 4'b1111 : blank_b;
            default: mask_d = 4'b1111;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] nib;
        assign nib = (state_d == OWN_B) ? data_b[gi*4 +: 4] : data_a[gi*4 +: 4];
        assign seg_d[gi*7 +: 7] = (state_d == IDLE) ? 7'b1111111 : hex_to_seg(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            seg_q      <= '1;
            mask_q     <= 4'b1111;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            seg_q      <= seg_d;
            mask_q     <= mask_d;
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign seg3  = seg_q[27:21];
    assign seg2  = seg_q[20:14];
    assign seg1  = seg_q[13:7];
    assign seg0  = seg_q[6:0];
    assign mask  = mask_q;

endmodule

// File: tb/tb_ss_display_arbiter.sv
// Bench for ss_display_arbiter: directed vector table, hand-written hold/blink/reset sequences,
// then random traffic against an ownership-timeline model.
module tb_ss_display_arbiter;
    localparam int HOLD = 8;
    localparam int BH   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic [15:0] data_a, data_b;
    logic [3:0]  blank_a, blank_b;
    logic        gnt_a, gnt_b;
    logic [6:0]  seg3, seg2, seg1, seg0;
    logic [3:0]  mask;

    ss_display_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .blank_a(blank_a),
        .req_b(req_b), .data_b(data_b), .blank_b(blank_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
        .mask(mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: who owns the display, and on which edge that ownership began.
    int m_owner = 0;  // 0 none, 1 A, 2 B
    int cyc     = 0;
    int a_start = 0;
    int b_start = 0;

    function automatic logic [27:0] enc_word(input logic [15:0] d);
        return {seg_tbl[d[15:12]], seg_tbl[d[11:8]], seg_tbl[d[7:4]], seg_tbl[d[3:0]]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        cyc++;
        if (rst) begin
            m_owner = 0;
        end else begin
            case (m_owner)
                0: begin
                    if (req_b)      begin m_owner = 2; b_start = cyc; end
                    else if (req_a) begin m_owner = 1; a_start = cyc; end
                end
                1: begin
                    if (!req_a) begin
                        if (req_b) begin m_owner = 2; b_start = cyc; end
                        else m_owner = 0;
                    end else if (req_b && (cyc - a_start) >= HOLD) begin
                        m_owner = 2; b_start = cyc;
                    end
                end
                default: begin
                    if (!req_b) begin
                        if (req_a) begin m_owner = 1; a_start = cyc; end
                        else m_owner = 0;
                    end
                end
            endcase
        end
    endtask

    function automatic logic model_dark();
`ifdef SS_DISPLAY_ARB_BLINK_EN
        return (((cyc - b_start) / BH) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_model(input string tag);
        logic        ega, egb;
        logic [3:0]  em;
        logic [27:0] es;
        ega = (m_owner == 1);
        egb = (m_owner == 2);
        case (m_owner)
            1:       begin em = blank_a; es = enc_word(data_a); end
            2:       begin em = model_dark() ? 4'b1111 : blank_b; es = enc_word(data_b); end
            default: begin em = 4'b1111; es = '1; end
        endcase
        chk({tag, "_gnt_a"}, 32'(gnt_a), 32'(ega));
        chk({tag, "_gnt_b"}, 32'(gnt_b), 32'(egb));
        chk({tag, "_mask"},  32'(mask),  32'(em));
        chk({tag, "_seg"},   32'({seg3, seg2, seg1, seg0}), 32'(es));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt_a"}, 32'(gnt_a), 32'd0);
        chk({tag, "_gnt_b"}, 32'(gnt_b), 32'd0);
        chk({tag, "_mask"},  32'(mask),  32'hF);
        chk({tag, "_seg"},   32'({seg3, seg2, seg1, seg0}), 32'h0FFF_FFFF);
    endtask

    typedef struct {
        logic        ra;
        logic [15:0] da;
        logic [3:0]  ba;
        logic        rb;
        logic [15:0] db;
        logic [3:0]  bb;
        logic        ega;
        logic        egb;
        logic [3:0]  em;
        logic [27:0] es;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 28'hFFF_FFFF};
        tbl[1] = '{1'b1, 16'h12AF, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 4'b0000,
                   {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
        tbl[2] = '{1'b1, 16'h0000, 4'b0101, 1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 4'b0101,
                   {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        tbl[3] = '{1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 28'hFFF_FFFF};
        tbl[4] = '{1'b1, 16'h0000, 4'b0000, 1'b1, 16'h3456, 4'b0010, 1'b0, 1'b1, 4'b0010,
                   {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
        tbl[5] = '{1'b1, 16'h789B, 4'b1000, 1'b0, 16'h3456, 4'b0000, 1'b1, 1'b0, 4'b1000,
                   {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}};
        tbl[6] = '{1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 28'hFFF_FFFF};

        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        data_a = '0; data_b = '0; blank_a = '0; blank_b = '0;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step();
            check_reset_vals($sformatf("idle%0d", i));
        end

        for (int i = 0; i < 7; i++) begin
            req_a = tbl[i].ra; data_a = tbl[i].da; blank_a = tbl[i].ba;
            req_b = tbl[i].rb; data_b = tbl[i].db; blank_b = tbl[i].bb;
            step();
            chk($sformatf("tbl%0d_gnt_a", i), 32'(gnt_a), 32'(tbl[i].ega));
            chk($sformatf("tbl%0d_gnt_b", i), 32'(gnt_b), 32'(tbl[i].egb));
            chk($sformatf("tbl%0d_mask", i),  32'(mask),  32'(tbl[i].em));
            chk($sformatf("tbl%0d_seg", i),   32'({seg3, seg2, seg1, seg0}), 32'(tbl[i].es));
        end

        // A granted at edge g, B requests from g+2, takeover exactly at g+8.
        req_a = 1'b1; data_a = 16'hC0DE; blank_a = 4'b0000;
        data_b = 16'hBEEF; blank_b = 4'b0000;
        step();
        chk("hold_g_gnt_a", 32'(gnt_a), 32'd1);
        step();
        chk("hold_g1_gnt_a", 32'(gnt_a), 32'd1);
        req_b = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            step();
            chk($sformatf("hold_g%0d_gnt_a", k), 32'(gnt_a), 32'd1);
            chk($sformatf("hold_g%0d_gnt_b", k), 32'(gnt_b), 32'd0);
        end
        for (int k = 0; k < 12; k++) begin
            logic [3:0] em;
            step();
`ifdef SS_DISPLAY_ARB_BLINK_EN
            em = ((k / BH) % 2 == 1) ? 4'b1111 : 4'b0000;
`else
            em = 4'b0000;
`endif
            if (k == 0) begin
                chk("preempt_gnt_b", 32'(gnt_b), 32'd1);
                chk("preempt_gnt_a", 32'(gnt_a), 32'd0);
            end
            chk($sformatf("blink%0d_mask", k), 32'(mask), 32'(em));
            chk($sformatf("blink%0d_seg", k), 32'({seg3, seg2, seg1, seg0}), 32'(enc_word(16'hBEEF)));
        end

        // Asynchronous reset between edges while B owns.
        #2;
        rst = 1'b1;
        m_owner = 0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_gnt_b", 32'(gnt_b), 32'd1);
        chk("post_rst_mask", 32'(mask), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0)  req_a = ~req_a;
            if ($urandom_range(0, 13) == 0) req_b = ~req_b;
            if ($urandom_range(0, 3) == 0)  data_a = 16'($urandom);
            if ($urandom_range(0, 3) == 0)  data_b = 16'($urandom);
            if ($urandom_range(0, 7) == 0)  blank_a = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  blank_b = 4'($urandom);
            step();
            check_model("rnd");
            chk("rnd_excl", 32'(gnt_a & gnt_b), 32'd0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1'b1;
                m_owner = 0;
                #1;
                check_reset_vals("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
